// File: rtl/vga_capture_if.sv
// Bus bundle for vga_capture: video input, CPU register/pixel port and ping-pong frame-RAM port.
// The slave modport is the capture block's view; the master modport drives it.
interface vga_capture_if;
  logic        pix_en;
  logic        vid_vs;
  logic        vid_de;
  logic        vid_pix;
  logic [23:0] addr;
  logic        we;
  logic        re;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        rvalid;
  logic [19:0] buf_wraddr;
  logic        buf_wrdata;
  logic        buf_wren0;
  logic        buf_wren1;
  logic [19:0] buf_rdaddr;
  logic        buf_q0;
  logic        buf_q1;

  modport slave (
    input  pix_en, vid_vs, vid_de, vid_pix,
    input  addr, we, re, datain,
    output dataout, rvalid,
    output buf_wraddr, buf_wrdata, buf_wren0, buf_wren1, buf_rdaddr,
    input  buf_q0, buf_q1
  );

  modport master (
    output pix_en, vid_vs, vid_de, vid_pix,
    output addr, we, re, datain,
    input  dataout, rvalid,
    input  buf_wraddr, buf_wrdata, buf_wren0, buf_wren1, buf_rdaddr,
    output buf_q0, buf_q1
  );
endinterface

// File: rtl/vga_capture.sv
// Video capture into a ping-pong pair of 1-bit frame RAMs addressed {y,x}; the CPU reads the
// last completed frame and a control/status register.
//
//  state   | meaning
//  IDLE    | not armed, no RAM writes
//  WAIT_VS | armed, waiting for the next vertical sync fall to start a frame
//  CAPTURE | writing active pixels into buffer cap_buf; each VS fall completes a frame
module vga_capture #(
  parameter int          H_ACT     = 640,
  parameter int          V_ACT     = 480,
  parameter logic [23:0] CTRL_ADDR = 24'hfffffc
) (
  input logic          clk,
  input logic          resetn,
  vga_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [10:0] H_LIM = 11'(H_ACT);
  localparam logic [10:0] V_LIM = 11'(V_ACT);

  state_t     state, state_nx;
  logic [9:0] x, y;
  logic       vs_q, de_q;
  logic       cap_buf, frame_done, ovf, cont;
  logic       vs_fall, line_end, in_win;
  logic       ctrl_wr, arm, disarm, clr;
  logic       wr_ok, clip, frame_end;
  logic       rvalid_q, rd_pix, rd_ctrl, rd_src;
  logic [3:0] rd_stat, status;
  logic       unused_bits;

  assign vs_fall  = bus.pix_en & vs_q & ~bus.vid_vs;
  assign line_end = bus.pix_en & de_q & ~bus.vid_de;
  assign in_win   = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);

  assign ctrl_wr = bus.we && (bus.addr == CTRL_ADDR);
  assign arm     = ctrl_wr & bus.datain[0];
  assign disarm  = ctrl_wr & ~bus.datain[0] & ~bus.datain[1];
  assign clr     = ctrl_wr & bus.datain[2];

  assign status      = {ovf, state != IDLE, frame_done, cap_buf};
  assign unused_bits = ^bus.datain[31:3];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Disarm overrides everything, including a frame end arriving in the same cycle.
  always_comb begin
    state_nx  = state;
    wr_ok     = 1'b0;
    clip      = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE:    if (arm) state_nx = WAIT_VS;
      WAIT_VS: if (vs_fall) state_nx = CAPTURE;
      CAPTURE: begin
        if (bus.pix_en && bus.vid_de) begin
          wr_ok = in_win;
          clip  = ~in_win;
        end
        if (vs_fall) begin
          frame_end = ~disarm;
          if (!cont) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (disarm) state_nx = IDLE;
  end

  assign bus.buf_wraddr = {y, x};
  assign bus.buf_wrdata = wr_ok & bus.vid_pix;
  assign bus.buf_wren0  = wr_ok & ~cap_buf;
  assign bus.buf_wren1  = wr_ok & cap_buf;
  assign bus.buf_rdaddr = bus.addr[19:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x          <= '0;
      y          <= '0;
      vs_q       <= 1'b1;
      de_q       <= 1'b0;
      cap_buf    <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
      cont       <= 1'b0;
    end else begin
      if (ctrl_wr) cont <= bus.datain[1];
      if (frame_end) cap_buf <= ~cap_buf;
      if (frame_end) frame_done <= 1'b1;
      else if (clr)  frame_done <= 1'b0;
      if (clip)     ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
      if (bus.pix_en) begin
        vs_q <= bus.vid_vs;
        de_q <= bus.vid_de;
        if (vs_fall) begin
          x <= '0;
          y <= '0;
        end else if (line_end) begin
          x <= '0;
          if (y != 10'h3ff) y <= y + 10'd1;
        end else if (bus.vid_de && x != 10'h3ff) begin
          x <= x + 10'd1;
        end
      end
    end
  end

  // Read source buffer and status are frozen at the re cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid_q <= 1'b0;
      rd_pix   <= 1'b0;
      rd_ctrl  <= 1'b0;
      rd_src   <= 1'b0;
      rd_stat  <= '0;
    end else begin
      rvalid_q <= bus.re;
      rd_ctrl  <= bus.re && (bus.addr == CTRL_ADDR);
      rd_pix   <= bus.re && (bus.addr[23:20] == 4'h0);
      rd_src   <= ~cap_buf;
      rd_stat  <= status;
    end
  end

  assign bus.rvalid = rvalid_q;

  always_comb begin
    bus.dataout = '0;
    if (rd_pix) begin
      bus.dataout[0] = rd_src ? bus.buf_q1 : bus.buf_q0;
    end else if (rd_ctrl) begin
      bus.dataout[3:0] = rd_stat;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture with a 4x2 active window and a behavioural pair of frame RAMs.
module tb_vga_capture;
  localparam logic [23:0] CTRL = 24'hfffffc;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  vga_capture_if bus();

  vga_capture #(
    .H_ACT     (4),
    .V_ACT     (2),
    .CTRL_ADDR (CTRL)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [22:0] wq[$];
  logic [31:0] rq[$];
  bit          mem0 [0:4095];
  bit          mem1 [0:4095];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // External 1-bit RAMs with registered read data.
  always @(posedge clk) begin
    if (bus.buf_wren0) mem0[bus.buf_wraddr[11:0]] <= bus.buf_wrdata;
    if (bus.buf_wren1) mem1[bus.buf_wraddr[11:0]] <= bus.buf_wrdata;
    bus.buf_q0 <= mem0[bus.buf_rdaddr[11:0]];
    bus.buf_q1 <= mem1[bus.buf_rdaddr[11:0]];
  end

  always @(negedge clk) begin
    if (bus.buf_wren0 || bus.buf_wren1) begin
      if (wq.size() == 0)
        check_val("wr_unexpected",
                  {9'b0, bus.buf_wren1, bus.buf_wren0, bus.buf_wraddr, bus.buf_wrdata}, 32'h0);
      else
        check_val("wr",
                  {9'b0, bus.buf_wren1, bus.buf_wren0, bus.buf_wraddr, bus.buf_wrdata},
                  {9'b0, wq.pop_front()});
    end
    if (bus.rvalid) begin
      if (rq.size() == 0) check_val("rd_unexpected", {31'b0, bus.rvalid}, 32'h0);
      else                check_val("rd", bus.dataout, rq.pop_front());
    end
  end

  task automatic vid(input logic vs, input logic de, input logic p);
    @(posedge clk); #1;
    bus.pix_en  = 1'b1;
    bus.vid_vs  = vs;
    bus.vid_de  = de;
    bus.vid_pix = p;
  endtask

  task automatic vs_pulse();
    vid(1'b0, 1'b0, 1'b0);
    vid(1'b1, 1'b0, 1'b0);
  endtask

  task automatic line(input int n, input logic [7:0] pat, input bit push, input bit b, input int yy);
    for (int i = 0; i < n; i++) begin
      if (push && i < 4 && yy < 2) wq.push_back({b, ~b, 10'(yy), 10'(i), pat[i]});
      vid(1'b1, 1'b1, pat[i]);
    end
    vid(1'b1, 1'b0, 1'b0);
    vid(1'b1, 1'b0, 1'b0);
  endtask

  task automatic cpu_wr(input logic [31:0] d);
    @(posedge clk); #1;
    bus.we = 1'b1; bus.addr = CTRL; bus.datain = d;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [23:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    bus.re = 1'b1; bus.addr = a;
    rq.push_back(exp);
    @(posedge clk); #1;
    bus.re = 1'b0;
    @(negedge clk); #1;
    check_val("rd_latency", rq.size(), 0);
  endtask

  task automatic status(input logic [3:0] e);
    cpu_rd(CTRL, {28'b0, e});
  endtask

  task automatic drain();
    check_val("wr_missing", wq.size(), 0);
  endtask

  // VS fall and a CTRL write landing in the same cycle.
  task automatic vs_we(input logic [31:0] d);
    @(posedge clk); #1;
    bus.vid_vs = 1'b0; bus.vid_de = 1'b0;
    bus.we = 1'b1; bus.addr = CTRL; bus.datain = d;
    @(posedge clk); #1;
    bus.we = 1'b0; bus.vid_vs = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    bus.pix_en = 1'b0; bus.vid_vs = 1'b1; bus.vid_de = 1'b0; bus.vid_pix = 1'b0;
    bus.addr = '0; bus.we = 1'b0; bus.re = 1'b0; bus.datain = '0;
    @(negedge clk);
    check_val("rst_wren", {30'b0, bus.buf_wren1, bus.buf_wren0}, 32'h0);
    check_val("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    check_val("rst_dataout", bus.dataout, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    status(4'b0000);

    // single 4x2 frame into buffer 0
    cpu_wr(32'h1);
    status(4'b0100);
    vs_pulse();
    line(4, 8'b1101, 1, 1'b0, 0);
    line(4, 8'b0010, 1, 1'b0, 1);
    vs_pulse();
    drain();
    status(4'b0011);
    cpu_rd(24'h000401, 32'h1);
    cpu_rd(24'h000001, 32'h0);
    cpu_rd(24'h000000, 32'h1);
    cpu_rd(24'h000403, 32'h0);
    cpu_rd(24'h100000, 32'h0);
    cpu_wr(32'h4);
    status(4'b0001);

    // continuous: three frames alternate buffers
    cpu_wr(32'h3);
    vs_pulse();
    line(4, 8'b0011, 1, 1'b1, 0);
    line(4, 8'b0001, 1, 1'b1, 1);
    vs_pulse();
    drain();
    status(4'b0110);
    line(4, 8'b1001, 1, 1'b0, 0);
    line(4, 8'b0101, 1, 1'b0, 1);
    vs_pulse();
    drain();
    status(4'b0111);
    line(4, 8'b0110, 1, 1'b1, 0);
    line(4, 8'b1000, 1, 1'b1, 1);
    vs_pulse();
    drain();
    status(4'b0110);
    cpu_rd(24'h000001, 32'h1);
    cpu_rd(24'h000000, 32'h0);
    cpu_rd(24'h000403, 32'h1);
    cpu_rd(24'h000400, 32'h0);

    // horizontal clipping sets ovf; bit2 clears it
    line(6, 8'b0011_1111, 1, 1'b0, 0);
    vs_pulse();
    drain();
    status(4'b1111);
    cpu_wr(32'h6);
    status(4'b0101);

    // disarm mid-capture
    line(4, 8'b1010, 1, 1'b1, 0);
    vs_pulse();
    drain();
    status(4'b0110);
    line(4, 8'b1111, 1, 1'b0, 0);
    cpu_wr(32'h0);
    status(4'b0010);
    line(4, 8'b1111, 0, 1'b0, 0);
    vs_pulse();
    drain();
    status(4'b0010);

    // frame end collides with clear (set wins), then with disarm (disarm wins)
    cpu_wr(32'h7);
    status(4'b0100);
    vs_pulse();
    vs_we(32'h6);
    status(4'b0111);
    vs_we(32'h0);
    status(4'b0011);

    // reset in the middle of an active line
    cpu_wr(32'h1);
    vs_pulse();
    wq.push_back({1'b1, 1'b0, 10'd0, 10'd0, 1'b1});
    vid(1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    bus.vid_de = 1'b1; bus.vid_pix = 1'b1;
    resetn = 1'b0;
    #1;
    check_val("rstmid_wren", {30'b0, bus.buf_wren1, bus.buf_wren0}, 32'h0);
    check_val("rstmid_wraddr", {12'b0, bus.buf_wraddr}, 32'h0);
    check_val("rstmid_wrdata", {31'b0, bus.buf_wrdata}, 32'h0);
    check_val("rstmid_rvalid", {31'b0, bus.rvalid}, 32'h0);
    check_val("rstmid_dataout", bus.dataout, 32'h0);
    repeat (3) vid(1'b1, 1'b1, 1'b1);
    @(posedge clk); #1 resetn = 1'b1;
    line(4, 8'b1111, 0, 1'b0, 0);
    vs_pulse();
    line(4, 8'b1111, 0, 1'b0, 0);
    drain();
    status(4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
